soma_sched: RTL

//  Timestep sequencer for the soma Vm datapath. Per timestep tick, sweeps neurons 0..N-1 through
//  the soma update pipeline (read, update, write-back), captures fire results into a spike FIFO
//  for the spike-out stage, and arbitrates host Vm read/write access against the sweep.

---
 rtl/soma_sched.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/soma_sched.sv
// rtl/soma_sched.sv - timestep sequencer for the soma Vm datapath
//
// Sweeps neurons 0..N-1 through the soma update pipeline once per requested
// tick, collects fire results into a small first-word-fall-through spike FIFO,
// runs clear sweeps that zero every Vm entry, and slots host Vm accesses in
// while the sweeper is idle.
//
// Ports
//   clk_soma, rst_n                 clock, asynchronous active-low reset
//   cfg_enable                      sweeps may start only while high
//   cfg_neuron_num                  neurons per sweep (0 = empty sweep)
//   tick_start, clear_start         request pulses (update / clear sweep)
//   soma_vld, soma_vm_addr          neuron issue to the soma pipeline
//   soma_clear                      issue is a clear, not an update
//   soma_fire                       fire result, one cycle after soma_vld
//   host_we, host_re                host request, held until host_gnt
//   host_addr, host_wdata           host address / write data
//   host_gnt                        host request accepted this cycle
//   host_rvalid                     soma read port data valid
//   soma_vm_we, soma_vm_re          host path strobes to soma Vm
//   soma_vm_waddr, soma_vm_raddr    host path addresses to soma Vm
//   soma_vm_wdata                   host path write data to soma Vm
//   spk_valid, spk_addr, spk_ready  spike FIFO head / consumer handshake
//   scan_busy                       sequencer not idle
//   sweep_done                      one-cycle pulse at end of sweep
//   stat_fire_cnt                   fires in last completed update sweep
//
// Build option: SOMA_SCHED_STAT_EN includes the per-sweep fire counter;
// without it stat_fire_cnt is tied to 0.

module soma_sched #(
  parameter int NNW   = 12,
  parameter int VW    = 20,
  parameter int DEPTH = 4
) (
  input  logic           clk_soma,
  input  logic           rst_n,
  input  logic           cfg_enable,
  input  logic [NNW-1:0] cfg_neuron_num,
  input  logic           tick_start,
  input  logic           clear_start,
  output logic           soma_vld,
  output logic [NNW-1:0] soma_vm_addr,
  output logic           soma_clear,
  input  logic           soma_fire,
  input  logic           host_we,
  input  logic           host_re,
  input  logic [NNW-1:0] host_addr,
  input  logic [VW-1:0]  host_wdata,
  output logic           host_gnt,
  output logic           host_rvalid,
  output logic           soma_vm_we,
  output logic           soma_vm_re,
  output logic [NNW-1:0] soma_vm_waddr,
  output logic [NNW-1:0] soma_vm_raddr,
  output logic [VW-1:0]  soma_vm_wdata,
  output logic           spk_valid,
  output logic [NNW-1:0] spk_addr,
  input  logic           spk_ready,
  output logic           scan_busy,
  output logic           sweep_done,
  output logic [NNW:0]   stat_fire_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]  FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0]  STALL_LVL = CW'(DEPTH - 1);
  localparam logic [NNW-1:0] ADDR_ONE  = NNW'(1);
  localparam logic [AW-1:0]  PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state;
  logic           pend_tick;
  logic           pend_clear;
  logic           sweep_clr;
  logic [NNW-1:0] addr;
  logic [NNW-1:0] n_lat;

  logic           vld_dly;
  logic           clear_dly;
  logic [NNW-1:0] addr_dly;

  logic [NNW-1:0] mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [CW-1:0]  fifo_count;

  logic start;
  logic issue;
  logic drain_exit;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic wr_en;
  logic pop;
  logic host_ok;

  // ---------------------------------------------------------------------------
  // Sweep control
  // ---------------------------------------------------------------------------
  assign start = (state == IDLE) && (pend_tick || pend_clear) && cfg_enable;

  // Stall keeps one FIFO slot free for the result already in flight, so a
  // fire can never arrive at a full FIFO even when every neuron fires.
  assign issue = (state == SCAN) && (n_lat != '0) && (fifo_count < STALL_LVL);

  assign drain_exit = (state == DRAIN) && !vld_dly && fifo_empty;

  assign soma_vld     = issue;
  assign soma_vm_addr = addr;
  assign soma_clear   = sweep_clr;

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pend_tick  <= 1'b0;
      pend_clear <= 1'b0;
      sweep_clr  <= 1'b0;
      addr       <= '0;
      n_lat      <= '0;
      scan_busy  <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SCAN;
            scan_busy <= 1'b1;
            addr      <= '0;
            n_lat     <= cfg_neuron_num;
            sweep_clr <= pend_clear;
            // A pending clear runs first; a pending tick waits for the next sweep.
            if (pend_clear) pend_clear <= 1'b0;
            else            pend_tick  <= 1'b0;
          end
        end
        SCAN: begin
          if (n_lat == '0) begin
            state <= DRAIN;
          end else if (issue) begin
            if (addr == n_lat - ADDR_ONE) state <= DRAIN;
            else                          addr  <= addr + ADDR_ONE;
          end
        end
        DRAIN: begin
          if (drain_exit) begin
            state      <= DONE;
            sweep_done <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          scan_busy <= 1'b0;
          sweep_clr <= 1'b0;
          addr      <= '0;
        end
        default: begin
          state     <= IDLE;
          scan_busy <= 1'b0;
        end
      endcase
      // Placed last so a request arriving on the cycle its flag is consumed
      // still registers as a new pending sweep.
      if (tick_start)  pend_tick  <= 1'b1;
      if (clear_start) pend_clear <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Fire capture, aligned with the soma's one-cycle result latency
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      vld_dly   <= 1'b0;
      clear_dly <= 1'b0;
      addr_dly  <= '0;
    end else begin
      vld_dly   <= issue;
      clear_dly <= sweep_clr;
      addr_dly  <= addr;
    end
  end

  assign push = vld_dly && !clear_dly && soma_fire;

  // ---------------------------------------------------------------------------
  // Spike FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_LVL);
  assign spk_valid  = !fifo_empty;
  assign spk_addr   = fifo_empty ? '0 : mem[rptr];
  assign pop        = spk_valid && spk_ready;
  assign wr_en      = push && (!fifo_full || pop);

  always_ff @(posedge clk_soma) begin
    if (wr_en) mem[wptr] <= addr_dly;
  end

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_ONE;
      if (pop)   rptr <= rptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Host access: only while the sweeper is idle and no sweep is launching, so
  // host reads never meet soma_vld and host writes never meet a result cycle.
  // ---------------------------------------------------------------------------
  assign host_ok       = (state == IDLE) && !vld_dly && !start;
  assign host_gnt      = host_ok && (host_we || host_re);
  assign soma_vm_we    = host_ok && host_we;
  assign soma_vm_re    = host_ok && host_re && !host_we;
  assign soma_vm_waddr = soma_vm_we ? host_addr  : '0;
  assign soma_vm_wdata = soma_vm_we ? host_wdata : '0;
  assign soma_vm_raddr = soma_vm_re ? host_addr  : '0;

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) host_rvalid <= 1'b0;
    else        host_rvalid <= soma_vm_re;
  end

  // ---------------------------------------------------------------------------
  // Fire statistics
  // ---------------------------------------------------------------------------
`ifdef SOMA_SCHED_STAT_EN
  localparam logic [NNW:0] ACC_ONE = (NNW + 1)'(1);

  logic [NNW:0] fire_acc;
  logic [NNW:0] stat_q;

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      fire_acc <= '0;
      stat_q   <= '0;
    end else begin
      if (start)                             fire_acc <= '0;
      else if (wr_en && (fire_acc != '1))    fire_acc <= fire_acc + ACC_ONE;
      // Published together with sweep_done; clear sweeps leave the last value.
      if (drain_exit && !sweep_clr)          stat_q   <= fire_acc;
    end
  end

  assign stat_fire_cnt = stat_q;
`else
  assign stat_fire_cnt = '0;
`endif

endmodule
